// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit built around one shared adder.
// Define MULTDIV_RADIX4_EN to multiply with radix-4 modified Booth recoding instead of radix-2.
module carry_lookahead_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c0,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             AneB
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             carry;
    logic             carry_prev;

    assign g    = A & B;
    assign p    = A ^ B;
    assign AneB = |p;

    always_comb begin
        carry      = c0;
        carry_prev = c0;
        out        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out[i]     = p[i] ^ carry;
            carry_prev = carry;
            carry      = g[i] | (p[i] & carry);
        end
        ovf = carry ^ carry_prev;
    end
endmodule

module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
`ifdef MULTDIV_RADIX4_EN
    localparam int AW      = WIDTH + 2;
    localparam int LAST_M  = WIDTH / 2 - 1;
`else
    localparam int AW      = WIDTH + 1;
    localparam int LAST_M  = WIDTH - 1;
`endif
    localparam int LAST_D  = WIDTH - 1;
    localparam int CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             is_mult_q, neg_q, div0_q, exc_q;
    logic [WIDTH-1:0] mcand_q, lo_q, lo_d, result_q;
    logic [AW-1:0]    hi_q, hi_d;
    logic [AW-1:0]    add_a, add_b, add_out;
    logic             add_c0, add_ovf, add_aneb, div_take, start, last_iter, mult_exc;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULTDIV_RADIX4_EN
    logic             booth_q;
    logic [AW-1:0]    m_ext, m2_ext;
    assign m_ext  = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    assign m2_ext = {mcand_q[WIDTH-1], mcand_q, 1'b0};
`endif

    // AneB is part of the shared adder's interface but this datapath never needs it.
    logic unused_aneb;
    assign unused_aneb = add_aneb;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign r_sh      = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign last_iter = (cnt_q == CW'(is_mult_q ? LAST_M : LAST_D));

    carry_lookahead_adder #(.WIDTH(AW)) u_adder (
        .A(add_a), .B(add_b), .c0(add_c0), .out(add_out), .ovf(add_ovf), .AneB(add_aneb)
    );

    // Adder operand selection: one iteration in RUN, sign correction in FIX.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_c0 = 1'b0;
        if (state_q == RUN) begin
            if (is_mult_q) begin
                add_a = hi_q;
`ifdef MULTDIV_RADIX4_EN
                case ({lo_q[1:0], booth_q})
                    3'b001, 3'b010: add_b = m_ext;
                    3'b011:         add_b = m2_ext;
                    3'b100:         begin add_b = ~m2_ext; add_c0 = 1'b1; end
                    3'b101, 3'b110: begin add_b = ~m_ext;  add_c0 = 1'b1; end
                    default:        add_b = '0;
                endcase
`else
                add_b = lo_q[0] ? AW'(mcand_q) : '0;
`endif
            end else begin
                add_a  = AW'(r_sh);
                add_b  = ~AW'(mcand_q);
                add_c0 = 1'b1;
            end
        end else if (state_q == FIX) begin
            add_a  = neg_q ? ~AW'(lo_q) : AW'(lo_q);
            add_c0 = neg_q;
        end
    end

    // Next iteration values; the trial subtraction keeps the result when it is non-negative.
    always_comb begin
        div_take = ~(add_out[AW-1] ^ add_ovf);
        if (is_mult_q) begin
`ifdef MULTDIV_RADIX4_EN
            hi_d = {{2{add_out[AW-1]}}, add_out[AW-1:2]};
            lo_d = {add_out[1:0], lo_q[WIDTH-1:2]};
`else
            hi_d = {1'b0, add_out[AW-1:1]};
            lo_d = {add_out[0], lo_q[WIDTH-1:1]};
`endif
        end else begin
            hi_d = div_take ? AW'(add_out[WIDTH-1:0]) : AW'(r_sh[WIDTH-1:0]);
            lo_d = {lo_q[WIDTH-2:0], div_take};
        end
`ifdef MULTDIV_RADIX4_EN
        mult_exc = ~((&{hi_q[WIDTH-1:0], lo_q[WIDTH-1]}) | ~(|{hi_q[WIDTH-1:0], lo_q[WIDTH-1]}));
`else
        // Magnitude fits when below 2^(W-1), or exactly 2^(W-1) for a negative product.
        mult_exc = (|hi_q[WIDTH-1:0]) | (lo_q[WIDTH-1] & ~(neg_q & ~(|lo_q[WIDTH-2:0])));
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (last_iter) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        data_resultRDY = (state_q == DONE);
        data_result    = result_q;
        data_exception = exc_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            is_mult_q <= 1'b0;
            neg_q     <= 1'b0;
            div0_q    <= 1'b0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
`ifdef MULTDIV_RADIX4_EN
            booth_q   <= 1'b0;
`endif
        end else if (start) begin
            cnt_q     <= '0;
            is_mult_q <= ctrl_MULT;
            hi_q      <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            div0_q    <= ~ctrl_MULT & ~(|data_operandB);
            neg_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (ctrl_MULT) begin
`ifdef MULTDIV_RADIX4_EN
                mcand_q <= data_operandA;
                lo_q    <= data_operandB;
                neg_q   <= 1'b0;
                booth_q <= 1'b0;
`else
                mcand_q <= a_mag;
                lo_q    <= b_mag;
`endif
            end else begin
                mcand_q <= b_mag;
                lo_q    <= a_mag;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
`ifdef MULTDIV_RADIX4_EN
            booth_q <= lo_q[1];
`endif
        end else if (state_q == FIX) begin
            result_q <= div0_q ? '0 : add_out[WIDTH-1:0];
            exc_q    <= is_mult_q ? mult_exc : (div0_q | (~neg_q & lo_q[WIDTH-1]));
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq: vector table plus restart/reset sequences.
module tb_multdiv_seq;
    localparam int W = 32;
`ifdef MULTDIV_RADIX4_EN
    localparam int MLAT = W / 2 + 1;
`else
    localparam int MLAT = W + 1;
`endif
    localparam int DLAT = W + 1;

    logic          clock, reset, ctrl_MULT, ctrl_DIV;
    logic [W-1:0]  data_operandA, data_operandB, data_result;
    logic          data_exception, data_resultRDY;

    multdiv_seq #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          mult;
        logic [31:0] res;
        logic        exc;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(input int lat, input string name, input logic [31:0] er, input logic ee);
        int          first;
        int          cnt;
        logic [31:0] r;
        logic        x;
        first = -1;
        cnt   = 0;
        r     = '0;
        x     = 1'b0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                cnt++;
                if (first < 0) begin
                    first = k;
                    r     = data_result;
                    x     = data_exception;
                end
            end
        end
        check({name, " latency"}, first, lat);
        check({name, " rdy_count"}, cnt, 1);
        check({name, " result"}, r, er);
        check({name, " exception"}, {31'b0, x}, {31'b0, ee});
        check({name, " hold"}, data_result, er);
        $display("%s: result=0x%08h exc=%0b rdy_edge=%0d rdy_cycles=%0d", name, r, x, first, cnt);
    endtask

    initial begin
        int rdy_seen;
        vecs[0]  = '{32'd6,        32'd7,        1'b1, 32'd42,       1'b0, "mul_6x7"};
        vecs[1]  = '{32'hFFFFFFFB, 32'd3,        1'b1, 32'hFFFFFFF1, 1'b0, "mul_m5x3"};
        vecs[2]  = '{32'h00010000, 32'h00010000, 1'b1, 32'h00000000, 1'b1, "mul_2p32"};
        vecs[3]  = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 1'b0, "mul_min_x1"};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1, "mul_min_xm1"};
        vecs[5]  = '{32'h40000000, 32'd2,        1'b1, 32'h80000000, 1'b1, "mul_2p31"};
        vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h00000001, 1'b1, "mul_max_sq"};
        vecs[7]  = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 1'b0, "div_m7_2"};
        vecs[8]  = '{32'd7,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 1'b0, "div_7_m2"};
        vecs[9]  = '{32'd100,      32'd7,        1'b0, 32'd14,       1'b0, "div_100_7"};
        vecs[10] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 32'd14,       1'b0, "div_m100_m7"};
        vecs[11] = '{32'h80000000, 32'd2,        1'b0, 32'hC0000000, 1'b0, "div_min_2"};
        vecs[12] = '{32'd7,        32'd0,        1'b0, 32'h00000000, 1'b1, "div_by_zero"};
        vecs[13] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, "div_overflow"};

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'b0, data_exception}, 32'd0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].mult, ~vecs[i].mult);
            check({vecs[i].name, " start_clear"}, {data_exception, data_result[30:0]}, 32'd0);
            wait_rdy(vecs[i].mult ? MLAT : DLAT, vecs[i].name, vecs[i].res, vecs[i].exc);
        end

        // A divide pulse ten cycles into a multiply replaces it.
        start_op(32'd3, 32'd3, 1'b1, 1'b0);
        rdy_seen = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("restart early_rdy", rdy_seen, 0);
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        wait_rdy(DLAT, "restart_div", 32'd14, 1'b0);

        start_op(32'd3, 32'd3, 1'b1, 1'b1);
        wait_rdy(MLAT, "both_ctrl", 32'd9, 1'b0);

        // Reset in the middle of RUN.
        start_op(32'd5, 32'd5, 1'b1, 1'b0);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset result", data_result, 32'd0);
        check("midreset exception", {31'b0, data_exception}, 32'd0);
        check("midreset rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < DLAT + 5; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("midreset no_rdy", rdy_seen, 0);
        $display("midreset: rdy_cycles_after_reset=%0d", rdy_seen);
        start_op(32'd2, 32'd2, 1'b1, 1'b0);
        wait_rdy(MLAT, "after_reset", 32'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
